// File: rtl/cordic_scheduler_if.sv
// Request/response bundle between the client blocks and cordic_scheduler.
//
// Handshake: a request from requester i transfers on a rising clk edge where
// req_valid[i] & req_ready[i] are both high. req_ready is derived
// combinationally from req_valid, so a requester must never wait for
// req_ready before raising req_valid. Responses carry no ready: each
// rsp_valid[i] pulse lasts one cycle and must be consumed in that cycle.
//
// Signals:
//   req_valid  [N]          per-requester request
//   req_ready  [N]          one-hot grant (or zero)
//   req_x/y/z  [N*WIDTH]    packed signed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid  [N]          one-hot result strobe
//   rsp_x/y    [WIDTH+1]    broadcast result bus
//   rsp_z      [WIDTH]      broadcast angle result
// Modports: master = client side, slave = scheduler side.
interface cordic_scheduler_if #(
  parameter int N     = 4,
  parameter int WIDTH = 16
);
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*WIDTH-1:0] req_x;
  logic [N*WIDTH-1:0] req_y;
  logic [N*WIDTH-1:0] req_z;
  logic [N-1:0]       rsp_valid;
  logic [WIDTH:0]     rsp_x;
  logic [WIDTH:0]     rsp_y;
  logic [WIDTH-1:0]   rsp_z;

  modport master (
    output req_valid, req_x, req_y, req_z,
    input  req_ready, rsp_valid, rsp_x, rsp_y, rsp_z
  );

  modport slave (
    input  req_valid, req_x, req_y, req_z,
    output req_ready, rsp_valid, rsp_x, rsp_y, rsp_z
  );
endinterface

// File: rtl/cordic_scheduler.sv
// cordic_scheduler: shares one fixed-latency CORDIC pipeline among N
// requesters. Round-robin arbitration issues at most one operation per clock;
// a tag (valid + requester index) travels alongside the CORDIC in a delay line
// and steers each result back to its originator as a one-hot strobe.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   issue_en          when low no new grants; in-flight work still returns
//   bus (slave)       request/response bundle, see cordic_scheduler_if
//   cordic_x0/y0/z0   registered operands presented to the CORDIC
//   cordic_x/y/z      CORDIC results (valid LATENCY cycles after x0/y0/z0)
//   in_flight         operations issued but not yet returned
//   idle              in_flight == 0 and no grant this cycle
module cordic_scheduler #(
  parameter int N       = 4,
  parameter int WIDTH   = 16,
  parameter int LATENCY = WIDTH + 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            issue_en,
  cordic_scheduler_if.slave               bus,
  output logic [WIDTH-1:0]                cordic_x0,
  output logic [WIDTH-1:0]                cordic_y0,
  output logic [WIDTH-1:0]                cordic_z0,
  input  logic [WIDTH:0]                  cordic_x,
  input  logic [WIDTH:0]                  cordic_y,
  input  logic [WIDTH-1:0]                cordic_z,
  output logic [$clog2(LATENCY+2)-1:0]    in_flight,
  output logic                            idle
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = $clog2(LATENCY + 2);

  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    ptr_d;
  logic [WIDTH-1:0] x0_q, y0_q, z0_q;
  logic [FW-1:0]    in_flight_q;
  logic             tag_v_q  [LATENCY+1];
  logic [IW-1:0]    tag_id_q [LATENCY+1];

  logic [N-1:0]     gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;
  logic [IW:0]      cand;
  logic             rsp_fire;

  // Rotating-priority search starting at the pointer. The candidate index is
  // wrapped by subtraction so non-power-of-two N works.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (issue_en && !reset) begin
      for (int k = 0; k < N; k++) begin
        cand = {1'b0, ptr_q} + (IW+1)'(k);
        if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
        if (!gnt_any && bus.req_valid[cand[IW-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = cand[IW-1:0];
        end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
    end
  end

  assign ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);

  // Gated with reset so a tag already at the end of the line when reset
  // rises never produces a pulse for pre-reset work.
  assign rsp_fire = tag_v_q[LATENCY] && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      x0_q        <= '0;
      y0_q        <= '0;
      z0_q        <= '0;
      ptr_q       <= '0;
      in_flight_q <= '0;
      for (int s = 0; s <= LATENCY; s++) begin
        tag_v_q[s]  <= 1'b0;
        tag_id_q[s] <= '0;
      end
    end else begin
      if (gnt_any) begin
        x0_q  <= bus.req_x[gnt_idx*WIDTH +: WIDTH];
        y0_q  <= bus.req_y[gnt_idx*WIDTH +: WIDTH];
        z0_q  <= bus.req_z[gnt_idx*WIDTH +: WIDTH];
        ptr_q <= ptr_d;
      end
      // The delay line never stalls: the CORDIC itself cannot stall.
      tag_v_q[0]  <= gnt_any;
      tag_id_q[0] <= gnt_idx;
      for (int s = 1; s <= LATENCY; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end
      case ({gnt_any, rsp_fire})
        2'b10:   in_flight_q <= in_flight_q + FW'(1);
        2'b01:   in_flight_q <= in_flight_q - FW'(1);
        default: in_flight_q <= in_flight_q;
      endcase
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    if (rsp_fire) bus.rsp_valid[tag_id_q[LATENCY]] = 1'b1;
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_x     = cordic_x;
  assign bus.rsp_y     = cordic_y;
  assign bus.rsp_z     = cordic_z;

  assign cordic_x0 = x0_q;
  assign cordic_y0 = y0_q;
  assign cordic_z0 = z0_q;
  assign in_flight = in_flight_q;
  assign idle      = (in_flight_q == '0) && !gnt_any;

endmodule

// File: tb/tb_cordic_scheduler.sv
module tb_cordic_scheduler;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int L  = W + 2;
  localparam int FW = $clog2(L + 2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          issue_en;
  logic [W-1:0]  cordic_x0, cordic_y0, cordic_z0;
  logic [W:0]    cordic_x, cordic_y;
  logic [W-1:0]  cordic_z;
  logic [FW-1:0] in_flight;
  logic          idle;

  cordic_scheduler_if #(.N(N), .WIDTH(W)) bus ();

  cordic_scheduler #(.N(N), .WIDTH(W), .LATENCY(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .issue_en  (issue_en),
    .bus       (bus),
    .cordic_x0 (cordic_x0),
    .cordic_y0 (cordic_y0),
    .cordic_z0 (cordic_z0),
    .cordic_x  (cordic_x),
    .cordic_y  (cordic_y),
    .cordic_z  (cordic_z),
    .in_flight (in_flight),
    .idle      (idle)
  );

  // Stand-in CORDIC: a fixed L-cycle pipeline applying simple invertible maps,
  // not reset (the real core keeps producing data across a scheduler reset).
  function automatic logic [W:0] fx(input logic [W-1:0] x);
    return {x[W-1], x} + 17'd17;
  endfunction
  function automatic logic [W:0] fy(input logic [W-1:0] y);
    return {y[W-1], y} ^ 17'h05a5a;
  endfunction
  function automatic logic [W-1:0] fz(input logic [W-1:0] z);
    return z + 16'h0101;
  endfunction

  logic [W-1:0] px [L];
  logic [W-1:0] py [L];
  logic [W-1:0] pz [L];
  always_ff @(posedge clk) begin
    px[0] <= cordic_x0;
    py[0] <= cordic_y0;
    pz[0] <= cordic_z0;
    for (int i = 1; i < L; i++) begin
      px[i] <= px[i-1];
      py[i] <= py[i-1];
      pz[i] <= pz[i-1];
    end
  end
  assign cordic_x = fx(px[L-1]);
  assign cordic_y = fy(py[L-1]);
  assign cordic_z = fz(pz[L-1]);

  // ---------------- reference model state ----------------
  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] x, y, z;
  } rsp_t;
  rsp_t exp_q[$];

  int           cyc = 0;
  int           m_ptr = 0;
  int           m_inflight = 0;
  logic [W-1:0] m_x0 = '0, m_y0 = '0, m_z0 = '0;
  bit           rand_ops = 1'b1;
  int           total = 0;
  int           bad = 0;

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Grant = valid requester with the smallest forward distance from the pointer.
  function automatic int model_grant(input logic [N-1:0] v);
    int best  = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i] && ((i - m_ptr + N) % N) < bestd) begin
        bestd = (i - m_ptr + N) % N;
        best  = i;
      end
    end
    return best;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  // Called just after a falling edge; drives inputs, checks the cycle, advances
  // the model across the next rising edge.
  task automatic step(input logic [N-1:0] v, input bit en, input bit rst);
    int   g;
    bit   popped;
    rsp_t e;
    logic [N-1:0] exp_ready, exp_rsp;
    reset         = rst;
    issue_en      = en;
    bus.req_valid = v;
    if (rand_ops) begin
      for (int i = 0; i < N; i++) begin
        bus.req_x[i*W +: W] = W'($urandom);
        bus.req_y[i*W +: W] = W'($urandom);
        bus.req_z[i*W +: W] = W'($urandom);
      end
    end
    #1;
    g = (en && !rst) ? model_grant(v) : -1;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));

    exp_rsp = '0;
    popped  = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      popped = 1'b1;
      if (!rst) begin
        exp_rsp[e.id] = 1'b1;
        check("rsp_x", 32'(bus.rsp_x), 32'(fx(e.x)));
        check("rsp_y", 32'(bus.rsp_y), 32'(fy(e.y)));
        check("rsp_z", 32'(bus.rsp_z), 32'(fz(e.z)));
      end
    end
    check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
    check("in_flight", 32'(in_flight), 32'(m_inflight));
    check("idle", 32'(idle), 32'(m_inflight == 0 && exp_ready == '0));
    check("cordic_x0", 32'(cordic_x0), 32'(m_x0));
    check("cordic_y0", 32'(cordic_y0), 32'(m_y0));
    check("cordic_z0", 32'(cordic_z0), 32'(m_z0));

    if (rst) begin
      exp_q.delete();
      m_ptr = 0;
      m_inflight = 0;
      m_x0 = '0; m_y0 = '0; m_z0 = '0;
    end else begin
      if (g >= 0) begin
        e.due = cyc + 1 + L;
        e.id  = g;
        e.x   = bus.req_x[g*W +: W];
        e.y   = bus.req_y[g*W +: W];
        e.z   = bus.req_z[g*W +: W];
        exp_q.push_back(e);
        m_x0 = e.x; m_y0 = e.y; m_z0 = e.z;
        m_ptr = (g + 1) % N;
        m_inflight++;
      end
      if (popped) m_inflight--;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b1, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1;
    issue_en = 1'b0;
    bus.req_valid = '0;
    bus.req_x = '0; bus.req_y = '0; bus.req_z = '0;
    @(negedge clk);

    // Reset, then reset-state checks on the following idle cycles.
    step('0, 1'b0, 1'b1);
    step('1, 1'b1, 1'b1);
    idle_cycles(2);

    // Single request from requester 2 with fixed operands.
    rand_ops = 1'b0;
    bus.req_x[2*W +: W] = 16'h1234;
    bus.req_y[2*W +: W] = 16'h0000;
    bus.req_z[2*W +: W] = 16'h2000;
    step(4'b0100, 1'b1, 1'b0);
    rand_ops = 1'b1;
    idle_cycles(L + 3);

    // All requesters valid for 8 cycles: rotating grants, contiguous returns.
    // The pointer is 3 after the grant to 2, so move it to 0 first.
    step(4'b1000, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, 1'b0);
    idle_cycles(L + 3);

    // Fairness: requester 0 held, requester 3 pulses for one cycle.
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b1, 1'b0);
    step(4'b1001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b1, 1'b0);

    // issue_en low with requester 1 pending, then released.
    for (int i = 0; i < 5; i++) step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    idle_cycles(L + 3);

    // Reset with three operations in flight: none may ever return.
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0);
    idle_cycles(2);
    step('0, 1'b1, 1'b1);
    idle_cycles(1);
    step(4'b0100, 1'b1, 1'b0);
    idle_cycles(L + 3);

    // Continuous issue: accept and return in the same cycle at steady state.
    for (int i = 0; i < 2 * L + 5; i++) step(4'b1111, 1'b1, 1'b0);
    check("in_flight_steady", 32'(in_flight), 32'(L + 1));
    idle_cycles(L + 3);

    // Randomized traffic, enables and occasional resets.
    for (int i = 0; i < 400; i++)
      step(N'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) == 0));
    idle_cycles(L + 3);
    check("drained_in_flight", 32'(in_flight), 32'(0));
    check("drained_idle", 32'(idle), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cordic_scheduler.md
Name: cordic_scheduler

Overview:
- Shares one pipelined CORDIC core among N requesters.
- Accepts operand triples on per-requester valid/ready ports and arbitrates round-robin, issuing at most one operation per clock.
- Carries a requester tag alongside the fixed-latency CORDIC pipeline and routes each result back to its originator as a one-hot valid pulse.
- Sits between the client blocks and one CORDIC instance; the same `reset` drives both.

Parameters:
- N, 4, number of requesters (2..16).
- WIDTH, 16, operand width; matches the CORDIC `width`.
- LATENCY, WIDTH+2, cycles from the CORDIC input being presented to its output being valid (CORDIC iterations + 1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- issue_en  in  1  when low, no new grants; in-flight operations continue
- req_valid  in  N  per-requester request
- req_ready  out  N  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i]
- req_x, req_y, req_z  in  N*WIDTH each  packed signed operands; requester i occupies bits [i*WIDTH +: WIDTH]
- cordic_x0, cordic_y0, cordic_z0  out  WIDTH each  registered operands to the CORDIC
- cordic_x, cordic_y  in  WIDTH+1 each  CORDIC results
- cordic_z  in  WIDTH  CORDIC angle result
- rsp_valid  out  N  one-hot result strobe
- rsp_x, rsp_y  out  WIDTH+1 each  broadcast result bus
- rsp_z  out  WIDTH  broadcast result bus
- in_flight  out  $clog2(LATENCY+2)  operations issued but not yet returned
- idle  out  1  high when in_flight == 0 and no grant is asserted

Behaviour:
- Reset (synchronous, active-high) clears:
  - cordic_x0/y0/z0 to 0.
  - The tag delay line (valid bit plus requester index) to all-invalid.
  - in_flight to 0; the round-robin pointer to 0.
  - Consequences: rsp_valid = 0 and idle = 1 in the cycle after reset; req_ready = 0 while reset is high.
- Reset mid-operation discards every in-flight result. No rsp_valid pulses for operations accepted before reset, even though the CORDIC still produces data.
- Arbitration (combinational on req_valid):
  - When issue_en = 1, grant the first requester with req_valid high, searching from the pointer upward with wrap modulo N.
  - req_ready is one-hot or zero, and is zero whenever issue_en = 0.
  - req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
- Pointer update: after a grant to index g, pointer <= (g+1) mod N. With no grant, the pointer holds.
- Issue:
  - On an accepting edge, cordic_x0/y0/z0 <= the operands of the granted requester, and tag stage 0 <= {1, g}.
  - On a non-accepting edge, the operand registers hold their value and tag stage 0 <= invalid.
- Tag delay line: LATENCY+1 stages, shifted every clock and never stalled (the CORDIC cannot stall).
- Response timing:
  - A transfer in cycle c produces rsp_valid[g] = 1 in exactly cycle c+1+LATENCY, for one cycle.
  - In that cycle rsp_x/y/z equal cordic_x/y/z combinationally.
  - Back-to-back accepts yield back-to-back responses in the same order.
- rsp_valid is zero whenever the last tag stage is invalid. rsp_x/y/z then mirror the CORDIC outputs and are don't-care.
- There is no response backpressure: sinks must accept every pulse.
- in_flight:
  - Increments on accept and decrements on response; both in one cycle leave it unchanged.
  - Maximum value is LATENCY+1, reached under continuous issue.
- Simultaneous requests from all N requesters are served in N consecutive cycles in rotating order. No requester waits more than N-1 grants.
- Dropping issue_en while requests are pending: grants stop immediately; the pointer is preserved.

Test Plan:
- Reset, then a single request: N=4, WIDTH=16. Req 2 asserts x=0x1234, y=0x0000, z=0x2000 in cycle c → req_ready = 4'b0100 in cycle c; cordic_x0 = 0x1234 in c+1; rsp_valid = 4'b0100 only in cycle c+19, with rsp_x = cordic_x in that cycle; in_flight goes 0→1→0.
- All 4 requesters valid continuously for 8 cycles, pointer at 0 → grants 0,1,2,3,0,1,2,3; rsp_valid sequence identical and contiguous from c+19; in_flight peaks at 8.
- Fairness: req 0 held valid and req 3 pulses valid in cycle 5 → req 3 granted no later than cycle 6; pointer advances to 0 after the grant to 3.
- issue_en = 0 for cycles 10–14 with req 1 valid → req_ready = 0 throughout; grant in cycle 15; previously issued operations still return on schedule.
- Reset asserted in cycle c+5 with 3 operations in flight → no rsp_valid ever emitted for them; in_flight = 0 and idle = 1 from c+6; a new request accepted in c+7 returns at c+26.
- Accept and return in the same cycle (continuous issue at steady state) → in_flight stays constant at LATENCY+1 = 19.
